// File: rtl/grid_loader_pkg.sv
// grid_pkg: shared constants and types for the paper-roll grid loader.
//   CH_*            ASCII codes recognised in the input stream
//   loader_state_t  loader FSM state
//   char_class_t    decoded class of one input byte
package grid_pkg;

    localparam logic [7:0] CH_PAPER = 8'h40;   // '@'
    localparam logic [7:0] CH_EMPTY = 8'h2E;   // '.'
    localparam logic [7:0] CH_LF    = 8'h0A;   // '\n'
    localparam logic [7:0] CH_CR    = 8'h0D;   // '\r'

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [2:0] {
        CC_PAPER,
        CC_EMPTY,
        CC_EOL,
        CC_SKIP,
        CC_BAD
    } char_class_t;

endpackage

// File: rtl/grid_loader_if.sv
// grid_loader_if: byte-stream valid/ready handshake into the grid loader.
//   in_data   8-bit ASCII byte (source -> loader)
//   in_valid  in_data is valid   (source -> loader)
//   in_ready  loader accepts a byte this cycle (loader -> source)
// Modports: master = byte source, slave = loader.
interface grid_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/grid_char_decode.sv
// grid_char_decode: combinational classifier for one input byte.
//   in_data     ASCII byte
//   char_class  CC_PAPER / CC_EMPTY / CC_EOL / CC_SKIP / CC_BAD
// Macro GRID_LOADER_CR_EN: when defined, carriage return is classed as
// CC_SKIP (so CRLF files load); otherwise it is CC_BAD.
module grid_char_decode
    import grid_pkg::*;
(
    input  logic [7:0]  in_data,
    output char_class_t char_class
);

    // Map the byte value onto its character class.
    always_comb begin
        char_class = CC_BAD;
        case (in_data)
            CH_PAPER: char_class = CC_PAPER;
            CH_EMPTY: char_class = CC_EMPTY;
            CH_LF:    char_class = CC_EOL;
`ifdef GRID_LOADER_CR_EN
            CH_CR:    char_class = CC_SKIP;
`else
            CH_CR:    char_class = CC_BAD;
`endif
            default:  char_class = CC_BAD;
        endcase
    end

endmodule

// File: rtl/grid_loader.sv
// grid_loader: loads a DEPTH x WIDTH paper grid from an ASCII byte stream.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse: clear grid and begin a new load
//   bus          grid_loader_if.slave (in_data / in_valid / in_ready)
//   mat          decoded grid, mat[row][col] = 1 for '@'
//   grid_valid   a complete, well-formed grid is held
//   err          malformed input seen since the last start (sticky)
//   rows_loaded  number of rows completed so far
// Macro GRID_LOADER_CR_EN: accept and ignore carriage returns.
module grid_loader
    import grid_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    grid_loader_if.slave                 bus,
    output logic [WIDTH-1:0]             mat [DEPTH-1:0],
    output logic                         grid_valid,
    output logic                         err,
    output logic [$clog2(DEPTH+1)-1:0]   rows_loaded
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(DEPTH + 1);

    loader_state_t    state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WIDTH-1:0] mat_q [DEPTH-1:0];
    logic [WIDTH-1:0] mat_d [DEPTH-1:0];
    logic             grid_valid_q, grid_valid_d;
    logic             err_q, err_d;

    char_class_t      char_class_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             bit_val_s;

    grid_char_decode u_decode (
        .in_data    (bus.in_data),
        .char_class (char_class_s)
    );

    // A start pulse wins over a byte in the same cycle.
    assign in_ready_s = (state_q == LOAD) && !start;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign bit_val_s  = (char_class_s == CC_PAPER);

    // Next-state, counter and matrix update for one accepted byte or start.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        mat_d        = mat_q;
        grid_valid_d = grid_valid_q;
        err_d        = err_q;

        if (start) begin
            state_d      = LOAD;
            col_d        = {COL_W{1'b0}};
            row_d        = {ROW_W{1'b0}};
            grid_valid_d = 1'b0;
            err_d        = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                mat_d[r] = {WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            case (char_class_s)
                CC_PAPER, CC_EMPTY: begin
                    if (col_q < COL_W'(WIDTH)) begin
                        // Write only the cell addressed by (row_q, col_q).
                        for (int r = 0; r < DEPTH; r++) begin
                            for (int c = 0; c < WIDTH; c++) begin
                                if ((row_q == ROW_W'(r)) && (col_q == COL_W'(c))) begin
                                    mat_d[r][c] = bit_val_s;
                                end else begin
                                    mat_d[r][c] = mat_q[r][c];
                                end
                            end
                        end
                        col_d = col_q + COL_W'(1);
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                CC_EOL: begin
                    if (col_q == COL_W'(WIDTH)) begin
                        col_d = {COL_W{1'b0}};
                        row_d = row_q + ROW_W'(1);
                        if (row_q == ROW_W'(DEPTH - 1)) begin
                            state_d      = DONE;
                            grid_valid_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        // Short or empty line.
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                CC_SKIP: begin
                    state_d = LOAD;
                end
                default: begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counter, flag and matrix registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            grid_valid_q <= 1'b0;
            err_q        <= 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                mat_q[r] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            grid_valid_q <= grid_valid_d;
            err_q        <= err_d;
            mat_q        <= mat_d;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign mat          = mat_q;
    assign grid_valid   = grid_valid_q;
    assign err          = err_q;
    assign rows_loaded  = row_q;

endmodule

// File: tb/tb_grid_loader.sv
// tb_grid_loader: randomized self-checking bench for grid_loader (3x3).
// A reference model reparses every byte accepted since the last start and
// is compared against the DUT on every falling clock edge.
module tb_grid_loader;
    import grid_pkg::*;

    localparam int W = 3;
    localparam int D = 3;
`ifdef GRID_LOADER_CR_EN
    localparam bit CR_EN = 1'b1;
`else
    localparam bit CR_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    grid_loader_if bus_if ();
    logic [W-1:0] mat [D-1:0];
    logic         grid_valid;
    logic         err;
    logic [1:0]   rows_loaded;

    grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus_if),
        .mat         (mat),
        .grid_valid  (grid_valid),
        .err         (err),
        .rows_loaded (rows_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    byte unsigned acc[$];
    bit           started  = 1'b0;
    int           n_acc    = 0;
    int           m_rows   = 0;
    bit           m_bad    = 1'b0;
    bit           m_done   = 1'b0;
    logic [W-1:0] m_mat [D];
    bit           check_en = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rebuild expected outputs from the accepted byte history.
    task automatic parse();
        int r = 0;
        int c = 0;
        m_bad  = 1'b0;
        m_done = 1'b0;
        for (int d = 0; d < D; d++) m_mat[d] = '0;
        foreach (acc[i]) begin
            if (m_bad || m_done) break;
            case (acc[i])
                CH_PAPER, CH_EMPTY: begin
                    if (c < W) begin
                        m_mat[r][c] = (acc[i] == CH_PAPER);
                        c++;
                    end else m_bad = 1'b1;
                end
                CH_LF: begin
                    if (c == W) begin
                        r++;
                        c = 0;
                        if (r == D) m_done = 1'b1;
                    end else m_bad = 1'b1;
                end
                CH_CR: if (!CR_EN) m_bad = 1'b1;
                default: m_bad = 1'b1;
            endcase
        end
        m_rows = r;
    endtask

    function automatic bit model_ready();
        return started && !m_bad && !m_done;
    endfunction

    // model update on each clock edge / reset
    initial begin
        parse();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                acc.delete();
                started = 1'b0;
            end else if (start) begin
                acc.delete();
                started = 1'b1;
            end else if (bus_if.in_valid && model_ready()) begin
                acc.push_back(bus_if.in_data);
                n_acc++;
            end
            parse();
        end
    end

    task automatic compare_all();
        chk("in_ready", int'(bus_if.in_ready), int'(model_ready() && !start));
        chk("grid_valid", int'(grid_valid), int'(m_done));
        chk("err", int'(err), int'(m_bad));
        chk("rows_loaded", int'(rows_loaded), m_rows);
        if (!m_bad) begin
            for (int r = 0; r < D; r++) chk("mat_row", int'(mat[r]), int'(m_mat[r]));
        end
    endtask

    // per-cycle compare, away from the rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(bit with_byte);
        start           = 1'b1;
        bus_if.in_valid = with_byte;
        bus_if.in_data  = CH_PAPER;
        step();
        start           = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic send(string s, int gap_pct);
        for (int i = 0; i < s.len(); i++) begin
            int n0;
            int t;
            if (!model_ready()) break;
            if (int'($urandom_range(99)) < gap_pct) begin
                bus_if.in_valid = 1'b0;
                bus_if.in_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) step();
            end
            bus_if.in_data  = s[i];
            bus_if.in_valid = 1'b1;
            n0 = n_acc;
            t  = 0;
            while (n_acc == n0 && t < 20) begin
                step();
                t++;
            end
            if (n_acc == n0) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout byte=%0d not accepted within 20 cycles", i);
                break;
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic offer_idle(int n);
        bus_if.in_data  = CH_PAPER;
        bus_if.in_valid = 1'b1;
        repeat (n) step();
        bus_if.in_valid = 1'b0;
    endtask

    function automatic string rand_grid(bit crlf, bit corrupt);
        string s = "";
        for (int r = 0; r < D; r++) begin
            for (int c = 0; c < W; c++) s = {s, ($urandom_range(1) == 1) ? "@" : "."};
            if (crlf) s = {s, "\r"};
            s = {s, "\n"};
        end
        if (corrupt) begin
            byte unsigned bad_set [4] = '{8'h0A, 8'h40, 8'h58, 8'h0D};
            int k = int'($urandom_range(s.len() - 1));
            s[k] = bad_set[$urandom_range(3)];
        end
        return s;
    endfunction

    initial begin
        int n0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        check_en = 1'b1;
        step();

        // reset state
        chk("reset_in_ready", int'(bus_if.in_ready), 0);
        chk("reset_rows", int'(rows_loaded), 0);
        chk("reset_err", int'(err), 0);

        // bytes offered in IDLE are ignored
        offer_idle(3);

        // clean grid, back-to-back
        do_start(1'b0);
        n0 = n_acc;
        send("@.@\n.@.\n@@@\n", 0);
        chk("pin_grid_valid", int'(grid_valid), 1);
        chk("pin_mat0", int'(mat[0]), 5);
        chk("pin_mat1", int'(mat[1]), 2);
        chk("pin_mat2", int'(mat[2]), 7);
        chk("pin_model_mat0", int'(m_mat[0]), 5);
        chk("pin_rows", int'(rows_loaded), 3);
        chk("pin_err", int'(err), 0);
        chk("pin_accepts", n_acc - n0, 12);
        offer_idle(3);
        chk("pin_done_hold", int'(mat[2]), 7);

        // start with a byte offered: byte dropped; then short row
        do_start(1'b1);
        send("@.\n", 0);
        chk("pin_short_err", int'(err), 1);
        chk("pin_short_ready", int'(bus_if.in_ready), 0);
        chk("pin_short_gv", int'(grid_valid), 0);

        // long row, then recover with gaps
        do_start(1'b0);
        send("@.@@", 0);
        chk("pin_long_err", int'(err), 1);
        do_start(1'b0);
        chk("pin_restart_err", int'(err), 0);
        chk("pin_restart_mat0", int'(mat[0]), 0);
        send("@.@\n.@.\n@@@\n", 40);
        chk("pin_gap_mat0", int'(mat[0]), 5);
        chk("pin_gap_mat1", int'(mat[1]), 2);
        chk("pin_gap_mat2", int'(mat[2]), 7);

        // CRLF
        do_start(1'b0);
        send("@.@\r\n.@.\r\n@@@\r\n", 0);
        if (CR_EN) begin
            chk("pin_crlf_gv", int'(grid_valid), 1);
            chk("pin_crlf_mat1", int'(mat[1]), 2);
        end else begin
            chk("pin_cr_err", int'(err), 1);
            chk("pin_cr_rows", int'(rows_loaded), 0);
        end

        // randomized grids, some corrupted, random gaps
        for (int it = 0; it < 40; it++) begin
            do_start($urandom_range(1) == 1);
            send(rand_grid(CR_EN && ($urandom_range(1) == 1), $urandom_range(3) == 0), 30);
            offer_idle(int'($urandom_range(0, 2)));
        end

        // asynchronous reset mid-load
        do_start(1'b0);
        send("@.@\n.", 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pin_rst_rows", int'(rows_loaded), 0);
        chk("pin_rst_mat0", int'(mat[0]), 0);
        chk("pin_rst_gv", int'(grid_valid), 0);
        chk("pin_rst_err", int'(err), 0);
        chk("pin_rst_ready", int'(bus_if.in_ready), 0);
        repeat (2) step();
        rst_n = 1'b1;
        offer_idle(3);
        chk("pin_post_rst_ready", int'(bus_if.in_ready), 0);
        do_start(1'b0);
        send("@.@\n.@.\n@@@\n", 20);
        chk("pin_post_rst_mat2", int'(mat[2]), 7);

        step();
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_loader.md
# grid_loader

Sequential front end for the paper-roll grid: accepts the puzzle input as an ASCII byte stream over a valid/ready handshake, decodes '@' and '.' into bits, and writes the `DEPTH` x `WIDTH` bit matrix. The accessibility counter consumes that matrix with `mat[row][col]` = 1 for paper. The loader validates row lengths and characters. It raises `grid_valid` only when a complete, well-formed grid is held.

## Interface
- `WIDTH`, 16: columns per row; characters before each newline.
- `DEPTH`, 16: number of rows.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; clears the grid and begins a new load.
- `in_data` input 8: ASCII byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mat` output `[WIDTH-1:0]` x `DEPTH` (unpacked `[DEPTH-1:0]`): decoded grid. Column c of row r is `mat[r][c]`, with the first character of a line at c = 0.
- `grid_valid` output 1: `mat` holds a complete, well-formed grid.
- `err` output 1: malformed input detected; sticky.
- `rows_loaded` output `$clog2(DEPTH+1)`: rows completed so far.

## Operation
- FSM states: IDLE, LOAD, DONE, ERROR.
- **Reset:** state IDLE. `mat` all 0. `in_ready`, `grid_valid`, `err` are 0. `rows_loaded` is 0. Internal column counter is 0.
- **`start` in any state:**
  - Clears `mat`, `rows_loaded`, the column counter and `err`.
  - Next state is LOAD.
  - `start` has priority over a byte in the same cycle; that byte is not accepted.
- **`in_ready`:** equals (state == LOAD) && !`start`. A byte is consumed when `in_valid` && `in_ready`.
- **Byte decode in LOAD:**
  - '@' (0x40): if col < `WIDTH`, write 1 to `mat[row][col]` and increment col; otherwise go to ERROR.
  - '.' (0x2E): same as '@', but writes 0.
  - '\n' (0x0A):
    - If col == `WIDTH`: `rows_loaded` increments and col resets to 0.
    - If that was row `DEPTH-1`, next state is DONE.
    - If col != `WIDTH` (short row, including an empty line): go to ERROR.
  - 0x0D: handling depends on Configuration.
  - Any other byte: go to ERROR.
- **DONE:** `grid_valid` = 1 and `in_ready` = 0. `mat` is held until `start` or reset.
- **ERROR:** `err` = 1, `in_ready` = 0 and `grid_valid` = 0. `mat` holds the partial contents and is don't-care to consumers.
- **IDLE:** `in_ready` = 0. Bytes are ignored.
- The final row must end with '\n'. A grid with no trailing newline never reaches DONE.
- **Width rule:** col counts 0..`WIDTH` in `$clog2(WIDTH+1)` bits. Row index counts 0..`DEPTH`.

## Timing
- One byte per cycle maximum. Back-to-back accepts are allowed with no bubbles.
- Bit write latency: `mat[r][c]` shows the decoded bit on the cycle after the accept edge.
- `grid_valid` rises the cycle after the final '\n' is accepted.
- `err` rises the cycle after the offending byte is accepted. From that cycle `in_ready` is 0.
- After a `start` pulse in cycle N, `in_ready` = 1 from cycle N+1 (if `start` is deasserted).
- `rst_n` assertion mid-load immediately forces all outputs to their reset values, independent of `clk`.
- Total accept cycles for a clean grid: `DEPTH` * (`WIDTH` + 1).

## Configuration
- Macro: `GRID_LOADER_CR_EN`.
- **Defined:** 0x0D is accepted and ignored in LOAD. It does not change col, row or `mat`, so CRLF input loads correctly.
- **Undefined:** 0x0D goes to ERROR, like any other illegal byte.

## Structure
- Package `grid_pkg`:
  - ASCII constants `CH_PAPER` (0x40), `CH_EMPTY` (0x2E), `CH_LF` (0x0A), `CH_CR` (0x0D).
  - Enum `loader_state_t` {IDLE, LOAD, DONE, ERROR}.
  - Enum `char_class_t` {CC_PAPER, CC_EMPTY, CC_EOL, CC_SKIP, CC_BAD}.
- Sub-module `grid_char_decode`:
  - Purely combinational: maps `in_data` to `char_class_t`.
  - `GRID_LOADER_CR_EN` selects CC_SKIP vs CC_BAD for 0x0D.
- `grid_loader` holds the FSM, counters and matrix register.

## Test plan
- `WIDTH`=`DEPTH`=3. After `start`, feed "@.@\n.@.\n@@@\n" with `in_valid` held high:
  - `mat[0]`=3'b101, `mat[1]`=3'b010, `mat[2]`=3'b111.
  - `grid_valid` rises one cycle after the 12th accept.
  - `rows_loaded`=3 and `err`=0.
- Short row "@.\n": `err`=1 on the cycle after the '\n' is accepted; `in_ready`=0 and `grid_valid`=0.
- Long row "@.@@": `err` rises after the 4th character. A following `start` clears `err` and `mat`, and the next clean grid loads correctly.
- "@.@\r\n..." with `GRID_LOADER_CR_EN` defined loads identically to the first scenario. Without the macro, `err`=1 after the 0x0D.
- Randomized `in_valid` gaps on the first scenario give the same `mat`. Bytes offered while `in_ready`=0 (IDLE, DONE, or a `start` cycle) are not consumed.
- Assert `rst_n`=0 after 5 accepted bytes: `mat`=0, `rows_loaded`=0, `grid_valid`=0, `err`=0 immediately. `in_ready` stays 0 until the next `start`.
